// File: rtl/psk_tx_pkg.sv
// Shared types and the bit-to-constellation mapping for the PSK transmit shaper.
package psk_tx_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    localparam logic MODE_BPSK = 1'b0;
    localparam logic MODE_QPSK = 1'b1;

    // Bit 0 -> +A, bit 1 -> -A; A <= 32767 so the negation never wraps.
    function automatic logic signed [15:0] map_bit(input logic b, input logic [14:0] amp);
        logic signed [15:0] w_pos;
        w_pos = {1'b0, amp};
        return b ? -w_pos : w_pos;
    endfunction

endpackage

// File: rtl/psk_tx_lerp.sv
// One rail of the symbol interpolator: registered prev + ((cur - prev) * cnt) >>> LOG2_SPS.
module psk_tx_lerp #(
    parameter int LOG2_SPS = 5,
    parameter int WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic signed [WIDTH-1:0] i_prev,
    input  logic signed [WIDTH-1:0] i_cur,
    input  logic [LOG2_SPS-1:0]     i_cnt,
    output logic signed [WIDTH-1:0] o_out
);

    localparam int PW = WIDTH + 1 + LOG2_SPS + 1;

    logic signed [WIDTH:0]  w_diff;
    logic signed [PW-1:0]   w_diff_ext;
    logic signed [PW-1:0]   w_cnt_ext;
    logic signed [PW-1:0]   w_prod;
    logic signed [PW-1:0]   w_step;

    assign w_diff     = {i_cur[WIDTH-1], i_cur} - {i_prev[WIDTH-1], i_prev};
    assign w_diff_ext = PW'(w_diff);
    assign w_cnt_ext  = PW'(i_cnt);
    assign w_prod     = w_diff_ext * w_cnt_ext;
    assign w_step     = w_prod >>> LOG2_SPS;

    // The interpolant stays between prev and cur, so truncating the step is lossless.
    always_ff @(posedge clk) begin
        if (srst) begin
            o_out <= '0;
        end else begin
            o_out <= i_prev + w_step[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/psk_tx_symbol_shaper.sv
// BPSK/QPSK symbol mapper with linear inter-symbol interpolation, SPS samples per symbol,
// idle-symbol insertion on underflow and a one-symbol ramp-down on stop.
module psk_tx_symbol_shaper
    import psk_tx_pkg::*;
#(
    parameter int LOG2_SPS = 5,
    parameter int WIDTH    = 16
) (
    input  logic                    clk_32M768,
    input  logic                    rst_32M768,
    input  logic                    enable,
    input  logic                    MODE,
    input  logic [WIDTH-2:0]        AMPLITUDE,
    input  logic [1:0]              s_tdata,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    output logic signed [WIDTH-1:0] I_tx,
    output logic signed [WIDTH-1:0] Q_tx,
    output logic                    tx_valid,
    output logic                    sym_strobe,
    output logic                    underflow,
    output logic                    busy
);

    state_t                  r_state;
    logic [LOG2_SPS-1:0]     r_cnt;
    logic signed [WIDTH-1:0] r_prev_i, r_prev_q, r_cur_i, r_cur_q;
    logic                    r_tx_valid;
    logic                    r_underflow;

    logic                    w_last, w_start, w_run_load, w_insert, w_prev_zero;
    logic signed [WIDTH-1:0] w_ld_i, w_ld_q, w_ins_i, w_ins_q;

    assign w_last     = (r_cnt == LOG2_SPS'((1 << LOG2_SPS) - 1));
    assign w_start    = !rst_32M768 && (r_state == S_IDLE) && enable && s_tvalid;
    assign w_run_load = !rst_32M768 && (r_state == S_RUN) && w_last && enable && s_tvalid;
    assign w_insert   = !rst_32M768 && (r_state == S_RUN) && w_last && enable && !s_tvalid;

    assign s_tready   = w_start || w_run_load;
    assign sym_strobe = s_tready || w_insert;

    assign w_ld_i = map_bit((MODE == MODE_QPSK) ? s_tdata[1] : s_tdata[0], AMPLITUDE);
    assign w_ld_q = (MODE == MODE_QPSK) ? map_bit(s_tdata[0], AMPLITUDE) : '0;

    // The idle symbol mirrors the symbol that is about to become prev, so the
    // receiver keeps seeing a zero crossing every symbol.
    assign w_prev_zero = (r_cur_i == '0) && (r_cur_q == '0);
    assign w_ins_i     = w_prev_zero ? $signed({1'b0, AMPLITUDE}) : -r_cur_i;
    assign w_ins_q     = w_prev_zero ? '0 : -r_cur_q;

    always_ff @(posedge clk_32M768) begin
        if (rst_32M768) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_prev_i    <= '0;
            r_prev_q    <= '0;
            r_cur_i     <= '0;
            r_cur_q     <= '0;
            r_tx_valid  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_tx_valid <= (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_start) begin
                        r_state     <= S_RUN;
                        r_cur_i     <= w_ld_i;
                        r_cur_q     <= w_ld_q;
                        r_prev_i    <= '0;
                        r_prev_q    <= '0;
                        r_underflow <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + LOG2_SPS'(1);
                    if (w_last) begin
                        r_prev_i <= r_cur_i;
                        r_prev_q <= r_cur_q;
                        if (w_run_load) begin
                            r_cur_i <= w_ld_i;
                            r_cur_q <= w_ld_q;
                        end else if (w_insert) begin
                            r_cur_i     <= w_ins_i;
                            r_cur_q     <= w_ins_q;
                            r_underflow <= 1'b1;
                        end else begin
                            r_cur_i <= '0;
                            r_cur_q <= '0;
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    r_cnt <= r_cnt + LOG2_SPS'(1);
                    if (w_last) begin
                        r_state  <= S_IDLE;
                        r_prev_i <= '0;
                        r_prev_q <= '0;
                        r_cur_i  <= '0;
                        r_cur_q  <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    psk_tx_lerp #(.LOG2_SPS(LOG2_SPS), .WIDTH(WIDTH)) u_lerp_i (
        .clk    (clk_32M768),
        .srst   (rst_32M768),
        .i_prev (r_prev_i),
        .i_cur  (r_cur_i),
        .i_cnt  (r_cnt),
        .o_out  (I_tx)
    );

    psk_tx_lerp #(.LOG2_SPS(LOG2_SPS), .WIDTH(WIDTH)) u_lerp_q (
        .clk    (clk_32M768),
        .srst   (rst_32M768),
        .i_prev (r_prev_q),
        .i_cur  (r_cur_q),
        .i_cnt  (r_cnt),
        .o_out  (Q_tx)
    );

    assign tx_valid  = r_tx_valid;
    assign underflow = r_underflow;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_psk_tx_symbol_shaper.sv
// Directed bench for psk_tx_symbol_shaper: expected I/Q samples are queued per symbol
// load and compared sample by sample as tx_valid samples come out.
module tb_psk_tx_symbol_shaper;

    localparam int SPS = 32;

    logic        clk_32M768 = 1'b0;
    logic        rst_32M768 = 1'b1;
    logic        enable     = 1'b1;
    logic        MODE       = 1'b1;
    logic [14:0] AMPLITUDE  = 15'd1000;
    logic [1:0]  s_tdata    = 2'b11;
    logic        s_tvalid   = 1'b1;
    logic        s_tready;
    logic signed [15:0] I_tx;
    logic signed [15:0] Q_tx;
    logic        tx_valid;
    logic        sym_strobe;
    logic        underflow;
    logic        busy;

    typedef struct {
        int i;
        int q;
    } samp_t;

    samp_t exp_q[$];
    int    n_pass  = 0;
    int    n_total = 0;
    int    m_cur_i = 0;
    int    m_cur_q = 0;

    always #5 clk_32M768 = ~clk_32M768;

    psk_tx_symbol_shaper dut (
        .clk_32M768 (clk_32M768),
        .rst_32M768 (rst_32M768),
        .enable     (enable),
        .MODE       (MODE),
        .AMPLITUDE  (AMPLITUDE),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .I_tx       (I_tx),
        .Q_tx       (Q_tx),
        .tx_valid   (tx_valid),
        .sym_strobe (sym_strobe),
        .underflow  (underflow),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] expv);
        n_total = n_total + 1;
        assert (obs === expv) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    function automatic int amap(input logic b);
        return b ? -int'(AMPLITUDE) : int'(AMPLITUDE);
    endfunction

    // Queue the 32 samples of a straight-line segment from the model's current target.
    task automatic push_seg(input int ni, input int nq);
        samp_t s;
        for (int k = 0; k < SPS; k++) begin
            s.i = m_cur_i + (((ni - m_cur_i) * k) >>> 5);
            s.q = m_cur_q + (((nq - m_cur_q) * k) >>> 5);
            exp_q.push_back(s);
        end
        m_cur_i = ni;
        m_cur_q = nq;
    endtask

    always @(negedge clk_32M768) begin
        if (tx_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sample", tx_valid, 0);
            end else begin
                samp_t e;
                e = exp_q.pop_front();
                check("I_sample", I_tx, e.i);
                check("Q_sample", Q_tx, e.q);
            end
        end
    end

    // Offer a symbol (called just after a rising edge) and wait for its handshake.
    task automatic send(input logic [1:0] d, input int exp_wait, input string tag);
        int w = 0;
        s_tdata  = d;
        s_tvalid = 1'b1;
        @(negedge clk_32M768);
        while (s_tready !== 1'b1 && w < 3 * SPS) begin
            @(negedge clk_32M768);
            w++;
        end
        check({tag, "_wait"}, w, exp_wait);
        check({tag, "_strobe"}, sym_strobe, 1);
        if (MODE) push_seg(amap(d[1]), amap(d[0]));
        else      push_seg(amap(d[0]), 0);
        $display("symbol %b mode %0d amp %0d loaded after %0d cycles", d, MODE, AMPLITUDE, w);
        @(posedge clk_32M768);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic skip_boundary(input int exp_wait);
        int w = 0;
        s_tvalid = 1'b0;
        @(negedge clk_32M768);
        while (sym_strobe !== 1'b1 && w < 3 * SPS) begin
            @(negedge clk_32M768);
            w++;
        end
        check("skip_wait", w, exp_wait);
        check("skip_tready", s_tready, 0);
        if (m_cur_i == 0 && m_cur_q == 0) push_seg(int'(AMPLITUDE), 0);
        else                              push_seg(-m_cur_i, -m_cur_q);
        $display("idle symbol inserted after %0d cycles", w);
        @(posedge clk_32M768);
        #1;
    endtask

    task automatic drain(input string tag);
        int w = 0;
        int n_rdy = 0;
        int n_stb = 0;
        enable = 1'b0;
        push_seg(0, 0);
        @(negedge clk_32M768);
        while (tx_valid === 1'b1 && w < 4 * SPS) begin
            if (s_tready === 1'b1) n_rdy++;
            if (sym_strobe === 1'b1) n_stb++;
            @(negedge clk_32M768);
            w++;
        end
        check({tag, "_txvalid_low"}, tx_valid, 0);
        check({tag, "_no_tready"}, n_rdy, 0);
        check({tag, "_no_strobe"}, n_stb, 0);
        check({tag, "_queue_left"}, exp_q.size(), 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_idle_tready"}, s_tready, 0);
        $display("%s: stopped after %0d cycles", tag, w);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset held with every input active
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_32M768);
            check("reset_I", I_tx, 0);
            check("reset_Q", Q_tx, 0);
            check("reset_ctrl", {tx_valid, s_tready, sym_strobe, underflow, busy}, 0);
        end
        @(posedge clk_32M768);
        #1;
        rst_32M768 = 1'b0;
        s_tvalid   = 1'b0;
        MODE       = 1'b0;
        AMPLITUDE  = 15'd16384;

        // 2: BPSK 0,1,0 back to back
        send(2'b00, 0, "bpsk0");
        send(2'b01, 31, "bpsk1");
        send(2'b00, 31, "bpsk2");

        // 3: QPSK 00 then 11 at A = 8192
        MODE      = 1'b1;
        AMPLITUDE = 15'd8192;
        send(2'b00, 31, "qpsk00");
        send(2'b11, 31, "qpsk11");

        // 4: underflow after (+A,-A)
        send(2'b01, 31, "qpsk01");
        check("underflow_before", underflow, 0);
        skip_boundary(31);
        check("underflow_set", underflow, 1);
        send(2'b10, 31, "qpsk10");
        check("underflow_sticky", underflow, 1);

        // 5: stop mid-symbol with a symbol pending
        repeat (5) @(posedge clk_32M768);
        #1;
        s_tdata  = 2'b11;
        s_tvalid = 1'b1;
        drain("drain");
        check("underflow_after_drain", underflow, 1);
        @(posedge clk_32M768);
        #1;
        s_tvalid  = 1'b0;
        enable    = 1'b1;
        MODE      = 1'b0;
        AMPLITUDE = 15'd16384;

        // 6: restart clears underflow, then reset at cnt = 10
        send(2'b01, 0, "restart1");
        check("underflow_cleared", underflow, 0);
        repeat (10) @(posedge clk_32M768);
        #1;
        rst_32M768 = 1'b1;
        @(posedge clk_32M768);
        @(negedge clk_32M768);
        check("midrst_I", I_tx, 0);
        check("midrst_Q", Q_tx, 0);
        check("midrst_ctrl", {tx_valid, s_tready, sym_strobe, underflow, busy}, 0);
        exp_q.delete();
        m_cur_i = 0;
        m_cur_q = 0;
        @(posedge clk_32M768);
        #1;
        rst_32M768 = 1'b0;
        send(2'b00, 0, "restart2");
        check("underflow_after_restart", underflow, 0);
        repeat (5) @(posedge clk_32M768);
        #1;
        drain("final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
